pcm_cpu_requester: RTL

- CPU-side initiator for the shared PCM memory port. Each CPU drives its memory request through one instance; the PCM_MM register block is the responder at the other end.
- Converts a CPU's SRAM-style strobes (CE/OE/WE/UB/LB, active-low) into the schedule/ready/resolved request handshake.
- Forms the 20-bit PCM address from the CPU index, holds the CPU until the access resolves, then returns the read data.

---
 rtl/pcm_req_pkg.sv | 26 ++
 rtl/pcm_cpu_requester.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/pcm_req_pkg.sv
// Shared types and constants for the PCM CPU requester.
// Holds the requester FSM state encoding, PCM bus widths and a lane-mask helper.
package pcm_req_pkg;

    localparam int PCM_ADDR_W = 20;
    localparam int PCM_DATA_W = 16;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        LOCAL,
        DONE,
        HOLD
    } req_state_t;

    // Zero every byte lane whose enable bit is clear.
    function automatic logic [PCM_DATA_W-1:0] lane_mask(
        input logic [PCM_DATA_W-1:0] data,
        input logic [1:0]            be
    );
        lane_mask = {be[1] ? data[15:8] : 8'h00,
                     be[0] ? data[7:0]  : 8'h00};
    endfunction

endpackage

// File: rtl/pcm_cpu_requester.sv
// CPU-side initiator for the shared PCM memory port.
// Ports: CPU SRAM strobes/addr/wdata in, mem_rdata/mem_ack out; PCM schedule/
// cpu_write/addr/cpu_out/byteen out, cpu_ready/resolved/cpu_in in; err, busy.
module pcm_cpu_requester
    import pcm_req_pkg::*;
#(
    parameter int              IDX_W    = 4,
    parameter int              TIMEOUT  = 1023,
    parameter logic [15:0]     ERR_DATA = 16'hFFFF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [15:0]           index,
    input  logic                  mem_ce_n,
    input  logic                  mem_oe_n,
    input  logic                  mem_we_n,
    input  logic                  mem_ub_n,
    input  logic                  mem_lb_n,
    input  logic [15:0]           mem_addr,
    input  logic [15:0]           mem_wdata,
    output logic [15:0]           mem_rdata,
    output logic                  mem_ack,
    output logic                  schedule,
    output logic                  cpu_write,
    output logic [PCM_ADDR_W-1:0] addr,
    output logic [PCM_DATA_W-1:0] cpu_out,
    output logic [1:0]            byteen,
    input  logic                  cpu_ready,
    input  logic                  resolved,
    input  logic [PCM_DATA_W-1:0] cpu_in,
    output logic                  err,
    output logic                  busy
);

    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] TO_V = CNT_W'(TIMEOUT);
    localparam bit TO_EN = (TIMEOUT != 0);
    localparam int IDX_PAD = PCM_ADDR_W - 16;

    req_state_t state_q, state_d;

    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [CNT_W-1:0]      cnt_inc;
    logic [15:0]           rdata_q, rdata_d;
    logic                  err_q, err_d;
    logic [PCM_ADDR_W-1:0] addr_q, addr_d;
    logic                  wr_q, wr_d;
    logic [15:0]           wdata_q, wdata_d;
    logic [1:0]            be_q, be_d;
    logic [1:0]            be_new;
    logic [IDX_PAD-1:0]    idx_pad;
    logic                  start;

    assign start   = !mem_ce_n && (!mem_we_n || !mem_oe_n);
    assign be_new  = {~mem_ub_n, ~mem_lb_n};
    assign cnt_inc = cnt_q + 1'b1;

    always_comb begin
        idx_pad = '0;
        idx_pad[IDX_W-1:0] = index[IDX_W-1:0];
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        addr_d  = addr_q;
        wr_d    = wr_q;
        wdata_d = wdata_q;
        be_d    = be_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    addr_d  = {idx_pad, mem_addr};
                    wr_d    = ~mem_we_n;
                    wdata_d = mem_wdata;
                    be_d    = be_new;
                    cnt_d   = '0;
                    // No lanes enabled: finish locally, PCM never sees it.
                    state_d = (be_new == 2'b00) ? LOCAL : REQ;
                end
            end
            REQ: begin
                if (cpu_ready) begin
                    if (resolved) begin
                        if (!wr_q) rdata_d = lane_mask(cpu_in, be_q);
                        state_d = DONE;
                    end else begin
                        cnt_d   = '0;
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (resolved) begin
                    if (!wr_q) rdata_d = lane_mask(cpu_in, be_q);
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_inc;
                    if (TO_EN && (cnt_inc == TO_V)) begin
                        err_d = 1'b1;
                        if (!wr_q) rdata_d = ERR_DATA;
                        state_d = DONE;
                    end
                end
            end
            LOCAL: begin
                if (!wr_q) rdata_d = '0;
                state_d = DONE;
            end
            DONE: begin
                state_d = HOLD;
            end
            HOLD: begin
                // Wait for CE release so a held strobe cannot re-issue.
                if (mem_ce_n) state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            addr_q  <= '0;
            wr_q    <= 1'b0;
            wdata_q <= '0;
            be_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            addr_q  <= addr_d;
            wr_q    <= wr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
        end
    end

    // Decoded from the state register so reset drops them at once.
    assign schedule  = (state_q == REQ);
    assign mem_ack   = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign mem_rdata = rdata_q;
    assign err       = err_q;
    assign addr      = addr_q;
    assign cpu_write = wr_q;
    assign cpu_out   = wdata_q;
    assign byteen    = be_q;

endmodule
